fetch_stage: RTL and testbench

Instruction fetch stage at the head of the processing pipeline. Holds the program counter and issues one-outstanding-request reads to instruction memory over a syn/ack handshake. Presents instruction/PC pairs to the decode stage, honouring stall, flush and PC redirect from the later stages. A one-entry skid buffer absorbs a response that returns while decode is stalled.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_skid_buffer.sv | 40 ++++
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, PC step and bubble NOP.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_INCR = 4;

    // Encoding of an empty slot (addi x0, x0, 0); f_o_ce=0 marks a bubble on the wire.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory syn/ack request/response bundle between fetch (master) and memory (slave).
interface fetch_stage_if #(
    parameter int unsigned AWIDTH_INSTR = 32,
    parameter int unsigned IWIDTH       = 32
) ();
    logic [AWIDTH_INSTR-1:0] f_o_addr_instr;
    logic                    f_o_syn;
    logic                    f_i_ack;
    logic [IWIDTH-1:0]       f_i_instr;

    modport master (
        output f_o_addr_instr,
        output f_o_syn,
        input  f_i_ack,
        input  f_i_instr
    );

    modport slave (
        input  f_o_addr_instr,
        input  f_o_syn,
        output f_i_ack,
        output f_i_instr
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry instruction/PC holding register used while decode is stalled.
module fetch_skid_buffer #(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_unload,
    input  logic                i_clear,
    input  logic [IWIDTH-1:0]   i_instr,
    input  logic [PC_WIDTH-1:0] i_pc,
    output logic                o_valid,
    output logic [IWIDTH-1:0]   o_instr,
    output logic [PC_WIDTH-1:0] o_pc
);
    logic                r_valid;
    logic [IWIDTH-1:0]   r_instr;
    logic [PC_WIDTH-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding syn/ack fetch, stall skid, flush and redirect.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets instead of aligning them.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          IWIDTH       = 32,
    parameter int unsigned          AWIDTH_INSTR = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
    input  logic                f_clk,
    input  logic                f_rst,
    input  logic                f_i_ce,
    input  logic                f_i_stall,
    input  logic                f_i_flush,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_pc,
    fetch_stage_if.master       mem,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic                f_o_ce,
    output logic                f_o_exception
);
    fetch_state_e            r_state;
    logic [PC_WIDTH-1:0]     r_pc;
    logic                    r_drop;
    logic                    r_parked;
    logic [AWIDTH_INSTR-1:0] r_addr;
    logic                    r_syn;
    logic [IWIDTH-1:0]       r_o_instr;
    logic [PC_WIDTH-1:0]     r_o_pc;
    logic                    r_o_ce;
    logic                    r_exception;

    logic                    w_kill, w_misalign, w_outstanding, w_start;
    logic [PC_WIDTH-1:0]     w_target, w_new_pc, w_pc_next;
    logic                    w_skid_load, w_skid_unload, w_skid_valid;
    logic [IWIDTH-1:0]       w_skid_instr;
    logic [PC_WIDTH-1:0]     w_skid_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misalign = f_i_change_pc && (f_i_pc[1:0] != 2'b00);
    assign w_target   = f_i_pc;
`else
    assign w_misalign = 1'b0;
    assign w_target   = f_i_pc & ~PC_WIDTH'(3);
`endif

    assign w_kill        = f_i_flush | f_i_change_pc;
    assign w_outstanding = (r_state == StReq) && !mem.f_i_ack;
    assign w_new_pc      = f_i_change_pc ? w_target : r_pc;
    assign w_start       = f_i_ce && (!r_parked || f_i_change_pc);
    assign w_pc_next     = r_pc + PC_WIDTH'(PC_INCR);

    assign w_skid_load   = !w_kill && (r_state == StReq) && mem.f_i_ack && !r_drop && f_i_stall;
    assign w_skid_unload = !w_kill && (r_state == StHold) && !f_i_stall;

    fetch_skid_buffer #(
        .IWIDTH   (IWIDTH),
        .PC_WIDTH (PC_WIDTH)
    ) u_skid (
        .clk      (f_clk),
        .rst      (f_rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_kill),
        .i_instr  (mem.f_i_instr),
        .i_pc     (r_pc),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            r_state     <= StIdle;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_parked    <= 1'b0;
            r_addr      <= AWIDTH_INSTR'(RESET_PC);
            r_syn       <= 1'b0;
            r_o_instr   <= '0;
            r_o_pc      <= '0;
            r_o_ce      <= 1'b0;
            r_exception <= 1'b0;
        end else begin
            r_exception <= 1'b0;
            if (w_kill) begin
                r_o_ce <= 1'b0;
                if (w_misalign) begin
                    r_exception <= 1'b1;
                    r_parked    <= 1'b1;
                    r_drop      <= 1'b0;
                    r_state     <= StIdle;
                    r_syn       <= 1'b0;
                end else begin
                    if (f_i_change_pc) begin
                        r_pc     <= w_target;
                        r_parked <= 1'b0;
                    end
                    // A pending request keeps its address until its ack, which is then discarded.
                    if (w_outstanding) begin
                        r_drop <= 1'b1;
                    end else begin
                        r_drop <= 1'b0;
                        if (w_start) begin
                            r_state <= StReq;
                            r_syn   <= 1'b1;
                            r_addr  <= AWIDTH_INSTR'(w_new_pc);
                        end else begin
                            r_state <= StIdle;
                            r_syn   <= 1'b0;
                        end
                    end
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (!f_i_stall) r_o_ce <= 1'b0;
                        if (f_i_ce && !r_parked) begin
                            r_state <= StReq;
                            r_syn   <= 1'b1;
                            r_addr  <= AWIDTH_INSTR'(r_pc);
                        end
                    end
                    StReq: begin
                        if (!mem.f_i_ack) begin
                            if (!f_i_stall) r_o_ce <= 1'b0;
                        end else if (r_drop) begin
                            r_drop <= 1'b0;
                            if (!f_i_stall) r_o_ce <= 1'b0;
                            if (f_i_ce) begin
                                r_addr <= AWIDTH_INSTR'(r_pc);
                            end else begin
                                r_state <= StIdle;
                                r_syn   <= 1'b0;
                            end
                        end else if (f_i_stall) begin
                            r_pc    <= w_pc_next;
                            r_state <= StHold;
                            r_syn   <= 1'b0;
                        end else begin
                            r_o_instr <= mem.f_i_instr;
                            r_o_pc    <= r_pc;
                            r_o_ce    <= 1'b1;
                            r_pc      <= w_pc_next;
                            if (f_i_ce) begin
                                r_addr <= AWIDTH_INSTR'(w_pc_next);
                            end else begin
                                r_state <= StIdle;
                                r_syn   <= 1'b0;
                            end
                        end
                    end
                    StHold: begin
                        if (!f_i_stall) begin
                            r_o_instr <= w_skid_instr;
                            r_o_pc    <= w_skid_pc;
                            r_o_ce    <= w_skid_valid;
                            if (f_i_ce) begin
                                r_state <= StReq;
                                r_syn   <= 1'b1;
                                r_addr  <= AWIDTH_INSTR'(r_pc);
                            end else begin
                                r_state <= StIdle;
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign mem.f_o_addr_instr = r_addr;
    assign mem.f_o_syn        = r_syn;
    assign f_o_instr          = r_o_instr;
    assign f_o_pc             = r_o_pc;
    assign f_o_ce             = r_o_ce;
    assign f_o_exception      = r_exception;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-by-cycle bench for fetch_stage with a one-cycle-latency instruction memory model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, ce, stall, flush, cp;
    logic [31:0] pc_in;
    logic [31:0] o_instr, o_pc;
    logic        o_ce, o_exc;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_instr = '0;
    int          n_total = 0;
    int          n_pass  = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.AWIDTH_INSTR(32), .IWIDTH(32)) bus ();

    fetch_stage #(
        .PC_WIDTH     (32),
        .IWIDTH       (32),
        .AWIDTH_INSTR (32),
        .RESET_PC     (32'h0)
    ) dut (
        .f_clk         (clk),
        .f_rst         (rst),
        .f_i_ce        (ce),
        .f_i_stall     (stall),
        .f_i_flush     (flush),
        .f_i_change_pc (cp),
        .f_i_pc        (pc_in),
        .mem           (bus),
        .f_o_instr     (o_instr),
        .f_o_pc        (o_pc),
        .f_o_ce        (o_ce),
        .f_o_exception (o_exc)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory acks one cycle after seeing syn; deliberately ignores reset so late acks happen.
    always @(posedge clk) begin
        mem_ack   <= bus.f_o_syn && !mem_ack;
        mem_instr <= mem_data(bus.f_o_addr_instr);
    end
    assign bus.f_i_ack   = mem_ack;
    assign bus.f_i_instr = mem_instr;

    typedef struct {
        logic        rst, ce, stall, flush, cp;
        logic [31:0] pc;
        logic        e_ce;
        logic [31:0] e_pc;
        logic        e_syn;
        logic [31:0] e_addr;
        logic        e_exc;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t v(input logic r, c, s, f, p, input logic [31:0] pc,
                               input logic ece, input logic [31:0] epc, input logic esyn,
                               input logic [31:0] eaddr, input logic eexc);
        vec_t t;
        t.rst = r; t.ce = c; t.stall = s; t.flush = f; t.cp = p; t.pc = pc;
        t.e_ce = ece; t.e_pc = epc; t.e_syn = esyn; t.e_addr = eaddr; t.e_exc = eexc;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [71:0] act,
                         input logic [71:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        //            rst ce st fl cp pc         ce pc         syn addr       exc
        vecs[0]  = v(1, 0, 0, 0, 0, 32'h0,    0, 32'h0,     0, 32'h0,     0);
        vecs[1]  = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h0,     1, 32'h0,     0);
        vecs[2]  = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h0,     1, 32'h0,     0);
        vecs[3]  = v(0, 1, 0, 0, 0, 32'h0,    1, 32'h0,     1, 32'h4,     0);
        vecs[4]  = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h0,     1, 32'h4,     0);
        vecs[5]  = v(0, 1, 0, 0, 0, 32'h0,    1, 32'h4,     1, 32'h8,     0);
        vecs[6]  = v(0, 1, 1, 0, 0, 32'h0,    1, 32'h4,     1, 32'h8,     0);
        vecs[7]  = v(0, 1, 1, 0, 0, 32'h0,    1, 32'h4,     0, 32'h8,     0);
        vecs[8]  = v(0, 1, 1, 0, 0, 32'h0,    1, 32'h4,     0, 32'h8,     0);
        vecs[9]  = v(0, 1, 0, 0, 0, 32'h0,    1, 32'h8,     1, 32'hC,     0);
        vecs[10] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h8,     1, 32'hC,     0);
        vecs[11] = v(0, 1, 0, 0, 0, 32'h0,    1, 32'hC,     1, 32'h10,    0);
        vecs[12] = v(0, 1, 0, 0, 1, 32'h100,  0, 32'hC,     1, 32'h10,    0);
        vecs[13] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'hC,     1, 32'h100,   0);
        vecs[14] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'hC,     1, 32'h100,   0);
        vecs[15] = v(0, 1, 0, 0, 0, 32'h0,    1, 32'h100,   1, 32'h104,   0);
        vecs[16] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h100,   1, 32'h104,   0);
        vecs[17] = v(0, 1, 0, 0, 1, 32'h100,  0, 32'h100,   1, 32'h100,   0);
        vecs[18] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h100,   1, 32'h100,   0);
        vecs[19] = v(0, 1, 0, 0, 0, 32'h0,    1, 32'h100,   1, 32'h104,   0);
        vecs[20] = v(0, 1, 1, 0, 0, 32'h0,    1, 32'h100,   1, 32'h104,   0);
        vecs[21] = v(0, 1, 1, 0, 0, 32'h0,    1, 32'h100,   0, 32'h104,   0);
        vecs[22] = v(0, 1, 1, 1, 0, 32'h0,    0, 32'h100,   1, 32'h108,   0);
        vecs[23] = v(0, 1, 1, 0, 0, 32'h0,    0, 32'h100,   1, 32'h108,   0);
        vecs[24] = v(0, 1, 0, 0, 0, 32'h0,    1, 32'h108,   1, 32'h10C,   0);
        vecs[25] = v(0, 0, 0, 0, 0, 32'h0,    0, 32'h108,   1, 32'h10C,   0);
        vecs[26] = v(0, 0, 0, 0, 0, 32'h0,    1, 32'h10C,   0, 32'h10C,   0);
        vecs[27] = v(0, 0, 0, 0, 0, 32'h0,    0, 32'h10C,   0, 32'h10C,   0);
`ifdef FETCH_MISALIGN_CHECK_EN
        vecs[28] = v(0, 1, 0, 0, 1, 32'h102,  0, 32'h10C,   0, 32'h10C,   1);
        vecs[29] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h10C,   0, 32'h10C,   0);
        vecs[30] = v(0, 1, 0, 0, 1, 32'h100,  0, 32'h10C,   1, 32'h100,   0);
`else
        vecs[28] = v(0, 1, 0, 0, 1, 32'h102,  0, 32'h10C,   1, 32'h100,   0);
        vecs[29] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h10C,   1, 32'h100,   0);
        vecs[30] = v(0, 1, 0, 0, 0, 32'h0,    1, 32'h100,   1, 32'h104,   0);
`endif
        vecs[31] = v(1, 1, 0, 0, 0, 32'h0,    0, 32'h0,     0, 32'h0,     0);
        vecs[32] = v(0, 0, 0, 0, 0, 32'h0,    0, 32'h0,     0, 32'h0,     0);
        vecs[33] = v(0, 1, 0, 0, 0, 32'h0,    0, 32'h0,     1, 32'h0,     0);

        rst = 1'b1; ce = 1'b0; stall = 1'b0; flush = 1'b0; cp = 1'b0; pc_in = '0;

        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; ce = vecs[i].ce; stall = vecs[i].stall;
            flush = vecs[i].flush; cp = vecs[i].cp; pc_in = vecs[i].pc;
            @(posedge clk);
            #1;
            check("state", i,
                  {5'b0, o_ce, bus.f_o_syn, o_exc, o_pc, bus.f_o_addr_instr},
                  {5'b0, vecs[i].e_ce, vecs[i].e_syn, vecs[i].e_exc, vecs[i].e_pc,
                   vecs[i].e_addr});
            if (vecs[i].e_ce) begin
                check("instr", i, {40'b0, o_instr}, {40'b0, mem_data(vecs[i].e_pc)});
            end
        end

        // After reset with a late ack ignored, the first delivered instruction must be pc 0.
        begin
            bit seen = 1'b0;
            @(negedge clk);
            cp = 1'b0; ce = 1'b1;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(posedge clk);
                #1;
                if (o_ce) seen = 1'b1;
            end
            check("first_after_reset_seen", 0, {71'b0, seen}, {71'b0, 1'b1});
            if (seen) begin
                check("first_after_reset_pc", 0, {40'b0, o_pc}, {40'b0, 32'h0});
                check("first_after_reset_instr", 0, {40'b0, o_instr},
                      {40'b0, mem_data(32'h0)});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
